// File: rtl/pool_tile_gather_pkg.sv
// -----------------------------------------------------------------------------
// pool_tile_gather_pkg
//   Shared constants for the 2x2 tile gatherer and its downstream write
//   controller: mesh/sum widths, line-buffer geometry, FSM state encoding and
//   the tile packing rule that both blocks must agree on.
// -----------------------------------------------------------------------------
package pool_tile_gather_pkg;

    localparam int X_MESH       = 16;  // mesh lanes
    localparam int COM_DATALEN  = 24;  // signed sum width
    localparam int MAX_LINE_LEN = 10;  // width of the line-length field
    localparam int MAX_ROW_LEN  = 10;  // width of the row-count field

    localparam int LANE_BUS_W = COM_DATALEN * X_MESH;   // one pixel, all lanes
    localparam int TILE_ELEMS = 4;                      // 2x2 tile
    localparam int TILE_BUS_W = TILE_ELEMS * LANE_BUS_W;

    // The line buffer stores one {odd px, even px} pair per entry.
    localparam int LB_AW    = MAX_LINE_LEN - 1;
    localparam int LB_DEPTH = 2 ** LB_AW;

    // Tile coordinates (row j, col k).
    localparam int TILE_ROW_TOP = 0;
    localparam int TILE_ROW_BOT = 1;
    localparam int TILE_COL_LFT = 0;
    localparam int TILE_COL_RGT = 1;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVEN = 2'd1;
    localparam logic [1:0] ST_ODD  = 2'd2;

    // Bit offset of tile element (row, col) of a lane inside out_data_4.
    function automatic int tile_offset(input int lane, input int row, input int col);
        return (col + 2 * row + TILE_ELEMS * lane) * COM_DATALEN;
    endfunction

endpackage

// File: rtl/pool_tile_gather_max4_signed.sv
// -----------------------------------------------------------------------------
// max4_signed
//   Combinational signed maximum of four COM_DATALEN-bit values, built as a
//   two-level compare tree.
//   Ports:
//     a0..a3  in   four signed operands
//     y       out  largest operand (signed compare over the full width)
// -----------------------------------------------------------------------------
module max4_signed
    import pool_tile_gather_pkg::*;
(
    input  logic signed [COM_DATALEN-1:0] a0,
    input  logic signed [COM_DATALEN-1:0] a1,
    input  logic signed [COM_DATALEN-1:0] a2,
    input  logic signed [COM_DATALEN-1:0] a3,
    output logic signed [COM_DATALEN-1:0] y
);

    logic signed [COM_DATALEN-1:0] m01;
    logic signed [COM_DATALEN-1:0] m23;

    assign m01 = (a1 > a0) ? a1 : a0;
    assign m23 = (a3 > a2) ? a3 : a2;
    assign y   = (m23 > m01) ? m23 : m01;

endmodule

// File: rtl/pool_tile_gather.sv
// -----------------------------------------------------------------------------
// pool_tile_gather
//   Collects raster-order MAC-mesh sums into 2x2 spatial tiles. Even rows are
//   parked pairwise in a half-line buffer; each odd-row, odd-column pixel
//   completes a tile, which is registered as the full tile (out_data_4) and
//   as its per-lane signed max (out_data_1) with a one-cycle out_valid strobe.
//   Ports:
//     clk, rst       clock / synchronous active-high reset
//     conf_input     pulse: latch linelen/rowcnt/pooled and start a frame
//     linelen        pixels per row (even, non-zero)
//     rowcnt         rows per frame (even, non-zero)
//     pooled         downstream selects out_data_1 (1) or out_data_4 (0)
//     in_valid       in_data carries one pixel for all lanes
//     in_data        lane i at [i*COM_DATALEN +: COM_DATALEN]
//     out_valid      strobe: tile / max valid
//     out_data_4     lane i element (j,k) at (k + 2j + 4i)*COM_DATALEN
//     out_data_1     per-lane max of the tile
//     busy           frame in progress
//     done           pulse with the final strobe of a frame
//     conf_err       sticky illegal-configuration flag
//     frame_pooled   latched pooled mode of the current configuration
// -----------------------------------------------------------------------------
module pool_tile_gather
    import pool_tile_gather_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    conf_input,
    input  logic [MAX_LINE_LEN-1:0] linelen,
    input  logic [MAX_ROW_LEN-1:0]  rowcnt,
    input  logic                    pooled,
    input  logic                    in_valid,
    input  logic [LANE_BUS_W-1:0]   in_data,
    output logic                    out_valid,
    output logic [TILE_BUS_W-1:0]   out_data_4,
    output logic [LANE_BUS_W-1:0]   out_data_1,
    output logic                    busy,
    output logic                    done,
    output logic                    conf_err,
    output logic                    frame_pooled
);

    localparam logic [MAX_LINE_LEN-1:0] LINE_ONE = {{(MAX_LINE_LEN-1){1'b0}}, 1'b1};
    localparam logic [MAX_ROW_LEN-1:0]  ROW_ONE  = {{(MAX_ROW_LEN-1){1'b0}}, 1'b1};

    logic [1:0]              state;
    logic [MAX_LINE_LEN-1:0] col;
    logic [MAX_ROW_LEN-1:0]  pair;
    logic [MAX_LINE_LEN-1:0] linelen_q;
    logic [MAX_ROW_LEN-1:0]  rowcnt_q;
    logic [LANE_BUS_W-1:0]   hold;

    logic [2*LANE_BUS_W-1:0] lb [LB_DEPTH];
    logic [LB_AW-1:0]        lb_idx;
    logic [2*LANE_BUS_W-1:0] lb_rd;

    logic [TILE_BUS_W-1:0]   tile;
    logic [LANE_BUS_W-1:0]   tile_max;

    logic conf_legal;
    logic accept;
    logic row_last;
    logic frame_last;
    logic tile_fire;

    assign conf_legal = (linelen != '0) && !linelen[0] && (rowcnt != '0) && !rowcnt[0];

    // A pixel arriving together with conf_input belongs to no frame.
    assign accept     = in_valid && (state != ST_IDLE) && !conf_input;
    assign row_last   = (col == linelen_q - LINE_ONE);
    assign frame_last = (pair == (rowcnt_q >> 1) - ROW_ONE);

    // The frame's last tile survives a coincident conf_input; every other
    // coincident pixel is dropped.
    assign tile_fire = in_valid && (state == ST_ODD) && col[0] &&
                       (!conf_input || (row_last && frame_last));

    assign lb_idx = col[MAX_LINE_LEN-1:1];
    assign lb_rd  = lb[lb_idx];

    // busy is a pure decode of the state register, so it rises the cycle
    // after a legal configuration and falls on the same edge that raises done.
    assign busy = (state != ST_IDLE);

    // Tile assembly: top row from the line buffer, bottom row from hold/px.
    for (genvar i = 0; i < X_MESH; i++) begin : g_lane
        logic [COM_DATALEN-1:0] e00, e01, e10, e11;

        assign e00 = lb_rd[i*COM_DATALEN +: COM_DATALEN];
        assign e01 = lb_rd[LANE_BUS_W + i*COM_DATALEN +: COM_DATALEN];
        assign e10 = hold[i*COM_DATALEN +: COM_DATALEN];
        assign e11 = in_data[i*COM_DATALEN +: COM_DATALEN];

        assign tile[tile_offset(i, TILE_ROW_TOP, TILE_COL_LFT) +: COM_DATALEN] = e00;
        assign tile[tile_offset(i, TILE_ROW_TOP, TILE_COL_RGT) +: COM_DATALEN] = e01;
        assign tile[tile_offset(i, TILE_ROW_BOT, TILE_COL_LFT) +: COM_DATALEN] = e10;
        assign tile[tile_offset(i, TILE_ROW_BOT, TILE_COL_RGT) +: COM_DATALEN] = e11;

        max4_signed u_max (
            .a0 (e00),
            .a1 (e01),
            .a2 (e10),
            .a3 (e11),
            .y  (tile_max[i*COM_DATALEN +: COM_DATALEN])
        );
    end

    // NOTE: line-buffer storage gets no reset -- a reset loop over a RAM array
    // prevents RAM inference, and every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (accept && (state == ST_EVEN) && col[0]) begin
            lb[lb_idx] <= {in_data, hold};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            pair         <= '0;
            linelen_q    <= '0;
            rowcnt_q     <= '0;
            frame_pooled <= 1'b0;
            hold         <= '0;
            out_valid    <= 1'b0;
            out_data_4   <= '0;
            out_data_1   <= '0;
            done         <= 1'b0;
            conf_err     <= 1'b0;
        end else begin
            out_valid <= tile_fire;
            done      <= 1'b0;

            if (tile_fire) begin
                out_data_4 <= tile;
                out_data_1 <= tile_max;
            end

            if (conf_input) begin
                col  <= '0;
                pair <= '0;
                if (conf_legal) begin
                    state        <= ST_EVEN;
                    linelen_q    <= linelen;
                    rowcnt_q     <= rowcnt;
                    frame_pooled <= pooled;
                    conf_err     <= 1'b0;
                end else begin
                    state    <= ST_IDLE;
                    conf_err <= 1'b1;
                end
            end else if (accept) begin
                if (!col[0]) begin
                    hold <= in_data;
                end

                if (row_last) begin
                    col <= '0;
                    if (state == ST_EVEN) begin
                        state <= ST_ODD;
                    end else if (frame_last) begin
                        state <= ST_IDLE;
                        pair  <= '0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_EVEN;
                        pair  <= pair + ROW_ONE;
                    end
                end else begin
                    col <= col + LINE_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_tile_gather.sv
// -----------------------------------------------------------------------------
// tb_pool_tile_gather
//   Self-checking bench: frames of random pixels are kept as a 2-D image;
//   every completed 2x2 tile is computed from that image and queued with the
//   cycle it must appear on. A negedge monitor compares strobes, tile data,
//   per-lane max and done against that queue.
// -----------------------------------------------------------------------------
module tb_pool_tile_gather;
    import pool_tile_gather_pkg::*;

    localparam int W = COM_DATALEN;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    conf_input;
    logic [MAX_LINE_LEN-1:0] linelen;
    logic [MAX_ROW_LEN-1:0]  rowcnt;
    logic                    pooled;
    logic                    in_valid;
    logic [LANE_BUS_W-1:0]   in_data;
    logic                    out_valid;
    logic [TILE_BUS_W-1:0]   out_data_4;
    logic [LANE_BUS_W-1:0]   out_data_1;
    logic                    busy;
    logic                    done;
    logic                    conf_err;
    logic                    frame_pooled;

    pool_tile_gather dut (
        .clk          (clk),
        .rst          (rst),
        .conf_input   (conf_input),
        .linelen      (linelen),
        .rowcnt       (rowcnt),
        .pooled       (pooled),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data_4   (out_data_4),
        .out_data_1   (out_data_1),
        .busy         (busy),
        .done         (done),
        .conf_err     (conf_err),
        .frame_pooled (frame_pooled)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TILE_BUS_W-1:0] d4;
        logic [LANE_BUS_W-1:0] d1;
        logic                  last;
        logic [31:0]           cyc;
    } exp_t;

    exp_t                  exp_q[$];
    logic [LANE_BUS_W-1:0] pix [8][16];
    logic [TILE_BUS_W-1:0] last_d4;
    logic [LANE_BUS_W-1:0] last_d1;
    logic [31:0]           cyc = 0;
    int                    n_tests = 0;
    int                    n_fail  = 0;
    int                    strobe_cnt = 0;
    int                    done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'({{(32-W){v[W-1]}}, v});
    endfunction

    function automatic logic [W-1:0] rand_px();
        case ($urandom_range(0, 7))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return 24'h000000;
            3:       return 24'hFFFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [LANE_BUS_W-1:0] rand_vec();
        logic [LANE_BUS_W-1:0] v;
        for (int i = 0; i < X_MESH; i++) v[i*W +: W] = rand_px();
        return v;
    endfunction

    task automatic fill_random(input int l, input int r);
        for (int y = 0; y < r; y++)
            for (int x = 0; x < l; x++) pix[y][x] = rand_vec();
    endtask

    task automatic set_lane(input int y, input int x, input int lane, input int val);
        pix[y][x][lane*W +: W] = val[W-1:0];
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected tile (tr, tc): image rows 2tr/2tr+1, columns 2tc/2tc+1.
    task automatic push_tile(input int tr, input int tc, input bit last);
        exp_t e;
        logic [W-1:0] v [4];
        int m;
        e = '0;
        for (int i = 0; i < X_MESH; i++) begin
            v[0] = pix[2*tr][2*tc][i*W +: W];
            v[1] = pix[2*tr][2*tc+1][i*W +: W];
            v[2] = pix[2*tr+1][2*tc][i*W +: W];
            v[3] = pix[2*tr+1][2*tc+1][i*W +: W];
            m = sx(v[0]);
            for (int el = 0; el < 4; el++) begin
                e.d4[(el + 4*i)*W +: W] = v[el];
                if (sx(v[el]) > m) m = sx(v[el]);
            end
            e.d1[i*W +: W] = m[W-1:0];
        end
        e.last = last;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic conf(input int l, input int r, input bit p);
        conf_input = 1'b1;
        linelen    = MAX_LINE_LEN'(l);
        rowcnt     = MAX_ROW_LEN'(r);
        pooled     = p;
        cycle();
        conf_input = 1'b0;
    endtask

    // Streams the current image. At pixel index stop_at the frame is cut
    // short: with abort_conf the pixel is sent together with a new legal
    // configuration (nl, nr), otherwise nothing more is driven. With
    // conf_last the final pixel carries a new configuration (nl, nr).
    task automatic run_frame(input int l, input int r, input int gmin, input int gmax,
                             input int stop_at, input bit abort_conf,
                             input bit conf_last, input int nl, input int nr);
        int  n;
        bit  fin;
        n = 0;
        for (int y = 0; y < r; y++) begin
            for (int x = 0; x < l; x++) begin
                int gap;
                gap = $urandom_range(gmin, gmax);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_data  = rand_vec();
                    cycle();
                end
                if (n == stop_at && !abort_conf) return;
                check("busy_in_frame", busy, 1);
                in_valid = 1'b1;
                in_data  = pix[y][x];
                if (n == stop_at) begin
                    conf_input = 1'b1;
                    linelen    = MAX_LINE_LEN'(nl);
                    rowcnt     = MAX_ROW_LEN'(nr);
                    pooled     = 1'($urandom);
                    cycle();
                    conf_input = 1'b0;
                    in_valid   = 1'b0;
                    return;
                end
                fin = (y == r - 1) && (x == l - 1);
                if ((y % 2 == 1) && (x % 2 == 1)) push_tile(y / 2, x / 2, fin && !conf_last);
                if (fin && conf_last) begin
                    conf_input = 1'b1;
                    linelen    = MAX_LINE_LEN'(nl);
                    rowcnt     = MAX_ROW_LEN'(nr);
                    pooled     = 1'($urandom);
                end
                cycle();
                conf_input = 1'b0;
                in_valid   = 1'b0;
                n++;
            end
        end
        check("busy_after_frame", busy, conf_last ? 1 : 0);
    endtask

    // Output monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (out_valid) begin
            strobe_cnt++;
            if (done) done_cnt++;
            last_d4 = out_data_4;
            last_d1 = out_data_1;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", out_valid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("done_with_strobe", done, e.last);
                for (int i = 0; i < X_MESH; i++) begin
                    for (int el = 0; el < 4; el++)
                        check($sformatf("d4_lane%0d_el%0d", i, el),
                              out_data_4[(el + 4*i)*W +: W], e.d4[(el + 4*i)*W +: W]);
                    check($sformatf("d1_lane%0d", i), out_data_1[i*W +: W], e.d1[i*W +: W]);
                end
            end
        end else begin
            check("done_without_strobe", done, 0);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check("missing_strobe", out_valid, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, d0;
        rst = 1'b1; conf_input = 1'b0; linelen = '0; rowcnt = '0; pooled = 1'b0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_conf_err", conf_err, 0);
        check("rst_d4_zero", 64'(|out_data_4), 0);
        check("rst_d1_zero", 64'(|out_data_1), 0);
        rst = 1'b0;
        cycle();

        // Basic tile, non-pooled, lane 0 = 1..4 / 5..8.
        conf(4, 2, 0);
        check("basic_busy", busy, 1);
        check("basic_conf_err", conf_err, 0);
        check("basic_pooled", frame_pooled, 0);
        fill_random(4, 2);
        for (int x = 0; x < 4; x++) begin
            set_lane(0, x, 0, x + 1);
            set_lane(1, x, 0, x + 5);
        end
        s0 = strobe_cnt; d0 = done_cnt;
        run_frame(4, 2, 0, 0, -1, 0, 0, 0, 0);
        cycle();
        check("basic_strobes", strobe_cnt - s0, 2);
        check("basic_dones", done_cnt - d0, 1);
        check("basic_l0_00", last_d4[0*W +: W], 3);
        check("basic_l0_01", last_d4[1*W +: W], 4);
        check("basic_l0_10", last_d4[2*W +: W], 7);
        check("basic_l0_11", last_d4[3*W +: W], 8);

        // Same stream with 3-cycle gaps before every pixel.
        conf(4, 2, 1);
        check("gap_pooled", frame_pooled, 1);
        run_frame(4, 2, 3, 3, -1, 0, 0, 0, 0);
        cycle();
        check("gap_l0_00", last_d4[0*W +: W], 3);
        check("gap_l0_11", last_d4[3*W +: W], 8);

        // Signed max: lane 3 all negative, lane 5 holds the max positive.
        conf(2, 2, 1);
        fill_random(2, 2);
        set_lane(0, 0, 3, -5);   set_lane(0, 1, 3, -2);
        set_lane(1, 0, 3, -9);   set_lane(1, 1, 3, -100);
        set_lane(0, 0, 5, 8388607); set_lane(0, 1, 5, -1);
        set_lane(1, 0, 5, -8388608); set_lane(1, 1, 5, -3);
        run_frame(2, 2, 0, 1, -1, 0, 0, 0, 0);
        cycle();
        check("max_lane3", last_d1[3*W +: W], 24'hFFFFFE);
        check("max_lane5", last_d1[5*W +: W], 24'h7FFFFF);

        // Multi-pair frame.
        conf(6, 4, 0);
        fill_random(6, 4);
        s0 = strobe_cnt; d0 = done_cnt;
        run_frame(6, 4, 0, 1, -1, 0, 0, 0, 0);
        cycle();
        check("multi_strobes", strobe_cnt - s0, 6);
        check("multi_dones", done_cnt - d0, 1);

        // Illegal configurations, pixels ignored while idle.
        conf(5, 2, 0);
        check("illegal_len_err", conf_err, 1);
        check("illegal_len_busy", busy, 0);
        s0 = strobe_cnt;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = rand_vec(); cycle();
        end
        in_valid = 1'b0;
        conf(4, 0, 0);
        check("illegal_row_err", conf_err, 1);
        cycle();
        check("illegal_no_strobes", strobe_cnt - s0, 0);
        conf(2, 2, 0);
        check("legal_clears_err", conf_err, 0);
        check("legal_busy", busy, 1);
        fill_random(2, 2);
        run_frame(2, 2, 0, 0, -1, 0, 0, 0, 0);

        // Abort mid-row with a new configuration, then run the new frame.
        conf(4, 4, 0);
        fill_random(4, 4);
        d0 = done_cnt;
        run_frame(4, 4, 0, 1, 6, 1, 0, 4, 2);
        fill_random(4, 2);
        run_frame(4, 2, 0, 1, -1, 0, 0, 0, 0);
        cycle();
        check("abort_dones", done_cnt - d0, 1);

        // New configuration on the final pixel: last tile kept, done dropped.
        conf(2, 2, 0);
        fill_random(2, 2);
        d0 = done_cnt;
        run_frame(2, 2, 0, 0, -1, 0, 1, 4, 2);
        fill_random(4, 2);
        run_frame(4, 2, 0, 0, -1, 0, 0, 0, 0);
        cycle();
        check("conf_last_dones", done_cnt - d0, 1);

        // Reset in the middle of a frame.
        conf(4, 4, 1);
        fill_random(4, 4);
        run_frame(4, 4, 0, 0, 8, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_conf_err", conf_err, 0);
        check("mid_rst_pooled", frame_pooled, 0);
        check("mid_rst_d4_zero", 64'(|out_data_4), 0);
        check("mid_rst_d1_zero", 64'(|out_data_1), 0);
        rst = 1'b0;
        cycle();

        // Random frames.
        for (int f = 0; f < 10; f++) begin
            int l, r;
            l = 2 * $urandom_range(1, 8);
            r = 2 * $urandom_range(1, 4);
            conf(l, r, 1'($urandom));
            fill_random(l, r);
            s0 = strobe_cnt;
            run_frame(l, r, 0, 2, -1, 0, 0, 0, 0);
            cycle();
            check("rand_strobes", strobe_cnt - s0, (l / 2) * (r / 2));
        end

        repeat (3) cycle();
        check("exp_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
